// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program counter driving the instruction address bus.
// Supports absolute load, increment, signed relative jump and call/return.
// Build option: define PC_STACK_EN to build the return-address stack. Without it
// CALL acts as an absolute load, RET is ignored and the stack status outputs
// are constant.
// Command priority: LOAD > RET > CALL > JMP_REL > LDPC.

module pc_sequencer #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              LOAD,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              LDPC,
   input  logic              JMP_REL,
   input  logic [ADDR_W-1:0] rel_offset,
   input  logic              CALL,
   input  logic              RET,
   output logic [ADDR_W-1:0] ABUSI,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              stack_err,
   output logic [SP_W-1:0]   sp_level
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;

   // Return address for CALL and the LDPC target share the same wrapped increment.
   assign pc_inc = pc_q + ADDR_W'(1);
   assign ABUSI  = pc_q;

`ifdef PC_STACK_EN

   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [SP_W-1:0]   sp_m1;
   logic              err_q, err_d;
   logic              push;
   logic              is_empty, is_full;
   logic [IDX_W-1:0]  wr_idx, rd_idx;

   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == SP_W'(STACK_DEPTH));
   assign sp_m1    = sp_q - SP_W'(1);
   // Only used when not full (push) or not empty (pop), so both indices stay in range.
   assign wr_idx   = sp_q[IDX_W-1:0];
   assign rd_idx   = sp_m1[IDX_W-1:0];

   // Next-state decode with fixed command priority.
   always_comb begin
      pc_d  = pc_q;
      sp_d  = sp_q;
      err_d = err_q;
      push  = 1'b0;
      if (LOAD) begin
         pc_d = load_addr;
      end else if (RET) begin
         if (!is_empty) begin
            pc_d = stack_q[rd_idx];
            sp_d = sp_m1;
         end else begin
            err_d = 1'b1;
         end
      end else if (CALL) begin
         if (!is_full) begin
            push = 1'b1;
            pc_d = load_addr;
            sp_d = sp_q + SP_W'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (JMP_REL) begin
         // Offset already spans the full address width, so sign extension is an identity.
         pc_d = pc_q + rel_offset;
      end else if (LDPC) begin
         pc_d = pc_inc;
      end
   end

   // PC, stack pointer and sticky error register with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pc_q  <= RESET_ADDR;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Stack storage needs no reset; reset blocks pushes so stale data is never read.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst && push) begin
         stack_q[wr_idx] <= pc_inc;
      end
   end

   assign stack_empty = is_empty;
   assign stack_full  = is_full;
   assign stack_err   = err_q;
   assign sp_level    = sp_q;

`else

   logic unused_ret;

   // RET has no effect without a stack.
   assign unused_ret = RET;

   // Next-state decode; CALL keeps its priority slot but acts as an absolute load.
   always_comb begin
      pc_d = pc_q;
      if (LOAD) begin
         pc_d = load_addr;
      end else if (CALL) begin
         pc_d = load_addr;
      end else if (JMP_REL) begin
         pc_d = pc_q + rel_offset;
      end else if (LDPC) begin
         pc_d = pc_inc;
      end
   end

   // PC register with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pc_q <= RESET_ADDR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign stack_empty = 1'b1;
   assign stack_full  = 1'b0;
   assign stack_err   = 1'b0;
   assign sp_level    = '0;

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed steps push expected state into a queue and a
// monitor compares the DUT after each clock edge. Covers both PC_STACK_EN builds.

module tb_pc_sequencer;

   logic       clk;
   logic       rst;
   logic       load, ldpc, jmp, call, ret;
   logic [7:0] load_addr, rel_offset;
   logic [7:0] abusi;
   logic       st_empty, st_full, st_err;
   logic [2:0] sp_level;

   typedef struct {
      logic [7:0] pc;
      logic [2:0] sp;
      logic       empty;
      logic       full;
      logic       err;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_id  = 0;

   pc_sequencer dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .LOAD       (load),
      .load_addr  (load_addr),
      .LDPC       (ldpc),
      .JMP_REL    (jmp),
      .rel_offset (rel_offset),
      .CALL       (call),
      .RET        (ret),
      .ABUSI      (abusi),
      .stack_empty(st_empty),
      .stack_full (st_full),
      .stack_err  (st_err),
      .sp_level   (sp_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id, input logic [7:0] got,
                      input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s step%0d got=%h expected=%h", nm, id, got, want);
      end
   endtask

   // Monitor: one expected entry per clock edge, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("abusi", e.id, abusi, e.pc);
            chk("sp_level", e.id, {5'b0, sp_level}, {5'b0, e.sp});
            chk("stack_empty", e.id, {7'b0, st_empty}, {7'b0, e.empty});
            chk("stack_full", e.id, {7'b0, st_full}, {7'b0, e.full});
            chk("stack_err", e.id, {7'b0, st_err}, {7'b0, e.err});
         end
      end
   end

   // One command cycle: drive strobes at the falling edge, queue the post-edge state.
   task automatic step(input logic s_rst, input logic s_load, input logic s_ret,
                       input logic s_call, input logic s_jmp, input logic s_ldpc,
                       input logic [7:0] la, input logic [7:0] ro,
                       input logic [7:0] e_pc, input logic [2:0] e_sp, input logic e_err);
      exp_t e;
      @(negedge clk);
      rst        = s_rst;
      load       = s_load;
      ret        = s_ret;
      call       = s_call;
      jmp        = s_jmp;
      ldpc       = s_ldpc;
      load_addr  = la;
      rel_offset = ro;
      e.pc    = e_pc;
      e.sp    = e_sp;
      e.empty = (e_sp == 3'd0);
      e.full  = (e_sp == 3'd4);
      e.err   = e_err;
      e.id    = step_id;
      step_id++;
      exp_q.push_back(e);
   endtask

   initial begin
      int guard;
      rst = 1'b1; load = 1'b0; ldpc = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
      load_addr = 8'h00; rel_offset = 8'h00;

      //    rst ld rt cl jr lp  la     ro     pc     sp  err
      // Reset for two cycles, then idle holds.
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      // Load then increment, including wrap from 0xFF.
      step(0, 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h12, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h13, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h14, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h15, 0, 0);
      step(0, 1, 0, 0, 0, 0, 8'hFE, 8'h00, 8'hFE, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFF, 0, 0);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0);
      // Relative jumps, both directions and wrap below zero.
      step(0, 1, 0, 0, 0, 0, 8'h20, 8'h00, 8'h20, 0, 0);
      step(0, 0, 0, 0, 1, 0, 8'h00, 8'hFC, 8'h1C, 0, 0);
      step(0, 0, 0, 0, 1, 0, 8'h00, 8'h05, 8'h21, 0, 0);
      step(0, 1, 0, 0, 0, 0, 8'h02, 8'h00, 8'h02, 0, 0);
      step(0, 0, 0, 0, 1, 0, 8'h00, 8'hFB, 8'hFD, 0, 0);
      // Priority: LOAD beats RET and LDPC; JMP_REL beats LDPC.
      step(0, 1, 1, 0, 0, 1, 8'h40, 8'h00, 8'h40, 0, 0);
      step(0, 0, 0, 0, 1, 1, 8'h00, 8'h02, 8'h42, 0, 0);

`ifdef PC_STACK_EN
      // Nested calls and returns.
      step(0, 1, 0, 0, 0, 0, 8'h30, 8'h00, 8'h30, 0, 0);
      step(0, 0, 0, 1, 0, 0, 8'h80, 8'h00, 8'h80, 1, 0);
      step(0, 0, 0, 1, 0, 0, 8'h90, 8'h00, 8'h90, 2, 0);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h81, 1, 0);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h31, 0, 0);
      // Fill the stack, overflow, drain in LIFO order, underflow.
      step(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      step(0, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h10, 1, 0);
      step(0, 0, 0, 1, 0, 0, 8'h20, 8'h00, 8'h20, 2, 0);
      step(0, 0, 0, 1, 0, 0, 8'h30, 8'h00, 8'h30, 3, 0);
      step(0, 0, 0, 1, 0, 0, 8'h40, 8'h00, 8'h40, 4, 0);
      step(0, 0, 0, 1, 0, 0, 8'h50, 8'h00, 8'h40, 4, 1);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h31, 3, 1);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h21, 2, 1);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h11, 1, 1);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1);
      step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h02, 0, 1);
      step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);
      // RET beats CALL, CALL beats JMP_REL, LOAD beats RET with a non-empty stack.
      step(0, 0, 0, 1, 0, 0, 8'h70, 8'h00, 8'h70, 1, 0);
      step(0, 0, 1, 1, 0, 0, 8'h99, 8'h00, 8'h01, 0, 0);
      step(0, 0, 0, 1, 1, 0, 8'hA0, 8'h05, 8'hA0, 1, 0);
      step(0, 1, 1, 0, 0, 1, 8'h40, 8'h00, 8'h40, 1, 0);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h02, 0, 0);
      // Back-to-back CALL then RET returns the just-pushed address.
      step(0, 0, 0, 1, 0, 0, 8'hC0, 8'h00, 8'hC0, 1, 0);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h03, 0, 0);
      // Reset overrides a CALL.
      step(0, 0, 0, 1, 0, 0, 8'hD0, 8'h00, 8'hD0, 1, 0);
      step(1, 0, 0, 1, 0, 0, 8'hB0, 8'h00, 8'h00, 0, 0);
`else
      // No stack: CALL loads, RET is ignored and lower strobes still act.
      step(0, 1, 0, 0, 0, 0, 8'h30, 8'h00, 8'h30, 0, 0);
      step(0, 0, 0, 1, 0, 0, 8'h55, 8'h00, 8'h55, 0, 0);
      step(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h55, 0, 0);
      step(0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 8'h56, 0, 0);
      step(0, 0, 0, 1, 1, 0, 8'h80, 8'h05, 8'h80, 0, 0);
      step(0, 0, 1, 1, 0, 0, 8'h90, 8'h00, 8'h90, 0, 0);
      step(0, 0, 1, 0, 1, 0, 8'h00, 8'h10, 8'hA0, 0, 0);
      // Reset overrides a CALL.
      step(1, 0, 0, 1, 0, 0, 8'h77, 8'h00, 8'h00, 0, 0);
`endif

      step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0);

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program counter for the CPU core; next generation of the 8-bit PC block.
- Drives the instruction address bus ABUSI.
- Supports absolute load, increment, signed relative jump, and call/return through an internal return-address stack.
- Sits between the control unit (command strobes) and instruction memory (address).

Parameters:
ADDR_W, 8, width of the address bus and of all address/offset ports
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, value loaded into ABUSI on reset

Ports:
sys_clk  input  1  system clock, all state updates on rising edge
sys_rst  input  1  synchronous reset, active-high
LOAD  input  1  absolute load of load_addr
load_addr  input  ADDR_W  load target and CALL target
LDPC  input  1  increment PC by 1
JMP_REL  input  1  relative jump by rel_offset
rel_offset  input  ADDR_W  signed two's-complement offset
CALL  input  1  push return address, jump to load_addr
RET  input  1  pop return address into PC
ABUSI  output  ADDR_W  registered program counter / instruction address
stack_empty  output  1  high when stack pointer = 0
stack_full  output  1  high when stack pointer = STACK_DEPTH
stack_err  output  1  sticky flag: overflow or underflow occurred
sp_level  output  clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset, sampled at rising sys_clk while sys_rst=1:
  - ABUSI=RESET_ADDR, sp_level=0, stack_err=0.
  - Stack contents are don't-care.
  - Reset overrides every command, including in mid-sequence.
- All commands are sampled at the rising edge; the result appears on ABUSI after that edge (1-cycle latency). No command asserted -> ABUSI holds.
- Fixed priority when several strobes are high: LOAD > RET > CALL > JMP_REL > LDPC. Only the highest-priority command acts; the others are ignored that cycle.
- LOAD: ABUSI <= load_addr.
- LDPC: ABUSI <= ABUSI+1 mod 2^ADDR_W. All-ones wraps to 0.
- JMP_REL: ABUSI <= ABUSI + sign-extended rel_offset, mod 2^ADDR_W. Wraps in both directions; no error flag.
- CALL, stack not full:
  - stack[sp] <= ABUSI+1 (wrapped), sp <= sp+1, ABUSI <= load_addr.
- CALL, stack full (overflow):
  - ABUSI, sp and stack unchanged; stack_err <= 1.
- RET, stack not empty:
  - ABUSI <= stack[sp-1], sp <= sp-1.
- RET, stack empty (underflow):
  - ABUSI and sp unchanged; stack_err <= 1.
- stack_err stays 1 until reset. Subsequent legal commands still execute normally.
- stack_empty, stack_full and sp_level are combinational decodes of the registered sp. They reflect the state after the last edge.
- Back-to-back CALL/RET on consecutive cycles is legal. A RET immediately after a CALL returns the address pushed by that CALL.

Optional Feature:
Macro PC_STACK_EN.
- Defined: call/return stack, CALL, RET, stack_empty, stack_full, stack_err and sp_level behave as above.
- Not defined:
  - No stack storage is built.
  - CALL behaves as LOAD (ABUSI <= load_addr, keeping CALL's priority slot).
  - RET is ignored (ABUSI holds unless a lower-priority command is active).
  - stack_empty=1, stack_full=0, stack_err=0, sp_level=0, all constant.
- Port list is identical in both builds.

Test Plan:
1. Defaults. Assert sys_rst 2 cycles, then release with all strobes low -> ABUSI=0x00, stack_empty=1, stack_err=0; ABUSI holds 0x00.
2. LOAD then LDPC. LOAD with load_addr=0x10 for 1 cycle, then LDPC for 5 cycles -> ABUSI 0x10,0x11..0x15. Repeat from load_addr=0xFE -> ABUSI 0xFE,0xFF,0x00 (wrap).
3. Relative jump. From ABUSI=0x20: JMP_REL with rel_offset=0xFC -> 0x1C. Then rel_offset=0x05 -> 0x21. From 0x02 with rel_offset=0xFB -> 0xFD.
4. Nested calls (PC_STACK_EN).
   - ABUSI=0x30; CALL to 0x80, CALL to 0x90, RET, RET -> ABUSI 0x80,0x90,0x81,0x31.
   - sp_level goes 1,2,1,0; stack_err stays 0.
5. Overflow/underflow (STACK_DEPTH=4).
   - 5 CALLs -> the 5th leaves ABUSI unchanged, stack_full=1, stack_err=1.
   - 4 RETs return the pushed addresses in LIFO order.
   - A 5th RET holds ABUSI with stack_err still 1.
   - Reset clears stack_err.
6. Priority and mid-op reset.
   - LOAD=1 with load_addr=0x40 and RET=1 and LDPC=1 -> ABUSI=0x40, sp unchanged.
   - sys_rst=1 together with CALL=1 -> ABUSI=0x00, sp_level=0.
   - Build without PC_STACK_EN: CALL to 0x55 -> ABUSI=0x55; RET -> ABUSI holds; stack_empty=1.
